output_port_fifo: RTL and testbench
===================================

OUTPUT_PORT_FIFO -- requirements
Module: output_port_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; equals processor output width.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, at least 2.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port outen, input, 1, write strobe from the processor datapath; one entry per high cycle.
REQ-006 Port out_data, input, WIDTH, processor output value; sampled when outen is high.
REQ-007 Port rd_valid, output, 1, high when the FIFO is non-empty and rd_data holds the head entry.
REQ-008 Port rd_ready, input, 1, consumer accepts the head entry when high together with rd_valid.
REQ-009 Port rd_data, output, WIDTH, head entry (show-ahead); 0 when empty.
REQ-010 Port count, output, clog2(DEPTH+1), number of stored entries.
REQ-011 Port full, output, 1, high when count equals DEPTH.
REQ-012 Port overflow, output, 1, sticky flag; set when a write is dropped.
REQ-013 Port last_out, output, WIDTH, most recently accepted write value, for LED/display use.

Function
REQ-014 The block SHALL be a circular buffer with a write pointer, a read pointer and a count register; pointers wrap from DEPTH-1 to 0.
REQ-015 Push condition SHALL be outen and (not full, or pop in the same cycle).
REQ-016 Pop condition SHALL be rd_valid and rd_ready.
REQ-017 Push only: store out_data at the write pointer, advance it, count+1.
REQ-018 Pop only: advance the read pointer, count-1.
REQ-019 Push and pop in the same cycle: both pointers advance, count unchanged; this applies when full as well.
REQ-020 Empty with outen high: the write SHALL be accepted; rd_valid SHALL rise the next cycle, with no fall-through in the same cycle.
REQ-021 Write-to-rd_valid latency SHALL be exactly 1 cycle; rd_data SHALL equal the written value in that cycle.
REQ-022 Data SHALL leave in write order, with no loss or duplication.
REQ-023 rd_ready while empty SHALL have no effect; count SHALL never underflow.
REQ-024 Full, outen high, no pop: the write SHALL be dropped, storage and pointers unchanged, overflow set to 1 the next cycle.
REQ-025 overflow SHALL remain 1 until reset.
REQ-026 last_out SHALL update to out_data on every accepted push, dropped writes excluded.
REQ-027 rd_valid SHALL equal (count != 0); full SHALL equal (count == DEPTH); both registered-state derived, not combinational from inputs.
REQ-028 rd_data SHALL be driven from storage at the read pointer, gated to 0 when empty.

Reset
REQ-029 While reset is high at a clock edge, the block SHALL set count=0, pointers=0, overflow=0, last_out=0, so rd_valid=0, full=0, rd_data=0 after the edge.
REQ-030 Reset SHALL take priority over a simultaneous push or pop; that push or pop SHALL be discarded.
REQ-031 Reset asserted mid-stream SHALL discard all stored entries; storage array contents need not be cleared.
REQ-032 Operation SHALL resume normally on the first edge with reset low.

Verification
REQ-033 Reset, then outen for 1 cycle with 8'hA5 -> next cycle rd_valid=1, rd_data=8'hA5, count=1, last_out=8'hA5.
REQ-034 Write 8'h01..8'h04 with rd_ready=0 -> full=1, count=4; fifth write 8'h05 -> overflow=1, count=4, last_out=8'h04; drain -> 01,02,03,04 in order, then rd_valid=0.
REQ-035 Full FIFO, outen=1 with 8'h77 and rd_ready=1 in the same cycle -> count stays 4, overflow stays 0, 8'h77 emerges after the three older entries.
REQ-036 Continuous outen and rd_ready for 10 cycles, values 0..9 -> count toggles 0/1 only, outputs 0..9 in order, pointers wrap without loss.
REQ-037 Empty, rd_ready=1 for 3 cycles -> count=0, rd_valid=0, rd_data=0 throughout.
REQ-038 Three entries stored and overflow=1, reset asserted 1 cycle together with outen -> count=0, overflow=0, rd_valid=0, last_out=0; next write accepted normally.

Source files
------------

// File: rtl/output_port_fifo.sv
// Show-ahead circular FIFO between the processor output port and its consumer.
// Writes to a full FIFO are dropped and latch a sticky overflow flag.
module output_port_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             outen,
   input  logic [WIDTH-1:0] out_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             overflow,
   output logic [WIDTH-1:0] last_out
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic [WIDTH-1:0] r_last;

   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [PW-1:0]    w_wptr_nxt;
   logic [PW-1:0]    w_rptr_nxt;

   assign rd_valid = (r_count != '0);
   assign full     = (r_count == CW'(DEPTH));
   assign count    = r_count;
   assign overflow = r_overflow;
   assign last_out = r_last;
   assign rd_data  = rd_valid ? r_mem[r_rptr] : '0;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
   assign w_pop  = rd_valid & rd_ready;
   assign w_push = outen & (~full | w_pop);
   assign w_drop = outen & ~w_push;

   assign w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
   assign w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_last     <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= w_wptr_nxt;
            r_last <= out_data;
         end
         if (w_pop) begin
            r_rptr <= w_rptr_nxt;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Storage needs no reset; rd_data is gated by rd_valid.
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_mem[r_wptr] <= out_data;
      end
   end

endmodule

// File: tb/tb_output_port_fifo.sv
// Self-checking bench: queue model checked every cycle, plus directed literals.
module tb_output_port_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             outen;
   logic [WIDTH-1:0] out_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] rd_data;
   logic [CW-1:0]    count;
   logic             full;
   logic             overflow;
   logic [WIDTH-1:0] last_out;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   logic [WIDTH-1:0] q[$];
   logic             m_ovf = 1'b0;
   logic [WIDTH-1:0] m_last = '0;

   output_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .outen(outen),
      .out_data(out_data),
      .rd_valid(rd_valid),
      .rd_ready(rd_ready),
      .rd_data(rd_data),
      .count(count),
      .full(full),
      .overflow(overflow),
      .last_out(last_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a bounded queue updated from the sampled inputs.
   always @(posedge clk) begin
      bit pop;
      bit push;
      if (reset) begin
         q.delete();
         m_ovf = 1'b0;
         m_last = '0;
      end else begin
         pop = (q.size() != 0) && rd_ready;
         push = outen && ((q.size() < DEPTH) || pop);
         if (outen && !push) m_ovf = 1'b1;
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(out_data);
            m_last = out_data;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_valid", 32'(rd_valid), 32'(q.size() != 0));
         check("m_data", 32'(rd_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
         check("m_count", 32'(count), 32'(q.size()));
         check("m_full", 32'(full), 32'(q.size() == DEPTH));
         check("m_ovf", 32'(overflow), 32'(m_ovf));
         check("m_last", 32'(last_out), 32'(m_last));
      end
   end

   task automatic step(input logic o, input logic [WIDTH-1:0] d,
                       input logic r);
      outen = o;
      out_data = d;
      rd_ready = r;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, '0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      outen = 1'b0;
      out_data = '0;
      rd_ready = 1'b0;
      step(1'b0, '0, 1'b0);
      chk_en = 1'b1;
      step(1'b0, '0, 1'b0);
      check("rst_valid", 32'(rd_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_data", 32'(rd_data), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_last", 32'(last_out), 32'd0);
      reset = 1'b0;

      step(1'b1, 8'hA5, 1'b0);
      check("a5_valid", 32'(rd_valid), 32'd1);
      check("a5_data", 32'(rd_data), 32'hA5);
      check("a5_count", 32'(count), 32'd1);
      check("a5_last", 32'(last_out), 32'hA5);
      step(1'b0, '0, 1'b1);
      check("a5_drained", 32'(rd_valid), 32'd0);

      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd4);
      step(1'b1, 8'h05, 1'b0);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd4);
      check("ovf_last", 32'(last_out), 32'h04);
      for (int i = 1; i <= 4; i++) begin
         check("drain_data", 32'(rd_data), 32'(i));
         step(1'b0, '0, 1'b1);
      end
      check("drain_empty", 32'(rd_valid), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);

      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
      step(1'b1, 8'h77, 1'b1);
      check("pp_count", 32'(count), 32'd4);
      check("pp_ovf", 32'(overflow), 32'd0);
      check("pp_head", 32'(rd_data), 32'h12);
      for (int i = 0; i < 3; i++) begin
         check("pp_old", 32'(rd_data), 32'(8'h12 + i));
         step(1'b0, '0, 1'b1);
      end
      check("pp_new", 32'(rd_data), 32'h77);
      step(1'b0, '0, 1'b1);

      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'(i), 1'b1);
         check("stream_count", 32'(count), 32'd1);
         check("stream_data", 32'(rd_data), 32'(i));
      end
      step(1'b0, '0, 1'b1);
      check("stream_end", 32'(count), 32'd0);

      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b1);
         check("empty_count", 32'(count), 32'd0);
         check("empty_valid", 32'(rd_valid), 32'd0);
         check("empty_data", 32'(rd_data), 32'd0);
      end

      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
      step(1'b0, '0, 1'b1);
      check("pre_count", 32'(count), 32'd3);
      check("pre_ovf", 32'(overflow), 32'd1);
      reset = 1'b1;
      step(1'b1, 8'h99, 1'b1);
      reset = 1'b0;
      check("mrst_count", 32'(count), 32'd0);
      check("mrst_ovf", 32'(overflow), 32'd0);
      check("mrst_valid", 32'(rd_valid), 32'd0);
      check("mrst_last", 32'(last_out), 32'd0);
      step(1'b1, 8'h42, 1'b0);
      check("resume_valid", 32'(rd_valid), 32'd1);
      check("resume_data", 32'(rd_data), 32'h42);
      check("resume_last", 32'(last_out), 32'h42);

      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         step(1'($urandom_range(0, 2) != 0), 8'($urandom),
              1'($urandom_range(0, 3) < (i / 100)));
      end
      reset = 1'b0;
      step(1'b0, '0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
